// File: rtl/data_bus.sv
// Data-side memory subsystem: byte-lane data RAM plus an optional memory-mapped TX-only UART.
// The UART, its FIFO and STATUS register are built only when DATA_BUS_UART_EN is defined.
module data_bus #(
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 8,
  parameter int BAUD_DIV   = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_ce_i,
  input  logic        ram_we_i,
  input  logic [31:0] ram_addr_i,
  input  logic [3:0]  ram_sel_i,
  input  logic [31:0] ram_data_i,
  output logic [31:0] ram_data_o,
  output logic        uart_tx_o
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam logic [31:0] TXDATA_ADDR = 32'h1000_0000;
  localparam logic [31:0] STATUS_ADDR = 32'h1000_0004;

  logic [31:0]   mem [RAM_WORDS];
  logic [AW-1:0] word_idx;
  logic          is_ram;
  logic          wr;
  logic          rd;
  logic [31:0]   status;

  assign word_idx = ram_addr_i[AW+1:2];
  assign is_ram   = (ram_addr_i[31:28] == 4'h0);
  assign wr       = ram_ce_i & ram_we_i;
  assign rd       = ram_ce_i & ~ram_we_i;

  // RAM is deliberately left out of reset; writes are held off while rst is high
  always_ff @(posedge clk) begin
    if (!rst && wr && is_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_sel_i[i]) mem[word_idx][8*i +: 8] <= ram_data_i[8*i +: 8];
      end
    end
  end

  always_comb begin
    ram_data_o = '0;
    if (rd && !rst) begin
      if (is_ram) ram_data_o = mem[word_idx];
      else if (ram_addr_i == STATUS_ADDR) ram_data_o = status;
    end
  end

`ifdef DATA_BUS_UART_EN
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [3:0]    DEPTH_C   = 4'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_LAST  = PW'(FIFO_DEPTH - 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  tx_state_t     state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic          tx;
  logic          pop;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [3:0]    count;
  logic          overflow;
  logic          full, empty;
  logic          push_req, push, ovf_set, ovf_clr;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == 4'd0);
  assign push_req = wr && (ram_addr_i == TXDATA_ADDR) && ram_sel_i[0];
  // A full FIFO still accepts a byte when the serializer pops in the same cycle
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign ovf_clr  = wr && (ram_addr_i == STATUS_ADDR) && ram_sel_i[0] && ram_data_i[3];
  assign status   = {24'b0, count, overflow, (state != IDLE), empty, full};

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= ram_data_i[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
    end
  end

  // Each state lasts BAUD_DIV cycles: the baud counter is loaded with BAUD_DIV-1 and advances at 0
  always_comb begin
    state_n   = state;
    baud_n    = baud;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    tx        = 1'b1;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_n = fifo_mem[rd_ptr];
          baud_n  = BAUD_LAST;
          state_n = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (baud == '0) begin
          baud_n    = BAUD_LAST;
          bit_idx_n = 3'd0;
          state_n   = DATA;
        end else begin
          baud_n = baud - 1'b1;
        end
      end
      DATA: begin
        tx = shift[0];
        if (baud == '0) begin
          baud_n  = BAUD_LAST;
          shift_n = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) state_n = STOP;
          else bit_idx_n = bit_idx + 3'd1;
        end else begin
          baud_n = baud - 1'b1;
        end
      end
      STOP: begin
        if (baud == '0) state_n = IDLE;
        else baud_n = baud - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  assign uart_tx_o = tx;
`else
  assign status    = '0;
  assign uart_tx_o = 1'b1;
`endif

endmodule

// File: tb/tb_data_bus.sv
// Scoreboard bench for data_bus: expected read data and UART line levels are queued
// when stimulus is driven and popped as the DUT produces them.
module tb_data_bus;
  localparam logic [31:0] TXDATA = 32'h1000_0000;
  localparam logic [31:0] STATUS = 32'h1000_0004;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ram_ce_i = 1'b0;
  logic        ram_we_i = 1'b0;
  logic [31:0] ram_addr_i = '0;
  logic [3:0]  ram_sel_i = '0;
  logic [31:0] ram_data_i = '0;
  logic [31:0] ram_data_o;
  logic        uart_tx_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] expQ[$];
  logic        txQ[$];
  logic [31:0] model [16];

  data_bus #(.RAM_WORDS(1024), .FIFO_DEPTH(8), .BAUD_DIV(4)) dut (
    .clk(clk), .rst(rst), .ram_ce_i(ram_ce_i), .ram_we_i(ram_we_i),
    .ram_addr_i(ram_addr_i), .ram_sel_i(ram_sel_i), .ram_data_i(ram_data_i),
    .ram_data_o(ram_data_o), .uart_tx_o(uart_tx_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; the following rising edge commits any write
  task automatic applyStimulus(input logic ce, input logic we, input logic [31:0] addr,
                               input logic [3:0] sel, input logic [31:0] data);
    @(negedge clk);
    ram_ce_i = ce; ram_we_i = we; ram_addr_i = addr; ram_sel_i = sel; ram_data_i = data;
  endtask

  task automatic readCheck(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    applyStimulus(1'b1, 1'b0, addr, 4'h0, 32'h0);
    expQ.push_back(exp);
    #1 checkOutput(tag, ram_data_o, expQ.pop_front());
  endtask

  initial begin
    logic [7:0]  b;
    logic [3:0]  sel;
    logic [31:0] d;
    int          idx;

    // reset state
    ram_ce_i = 1'b1; ram_addr_i = 32'h10;
    repeat (3) @(negedge clk);
    #1 checkOutput("rd_in_reset", ram_data_o, 32'h0);
    checkOutput("tx_reset", {31'b0, uart_tx_o}, 32'h1);
    rst = 1'b0;
`ifdef DATA_BUS_UART_EN
    readCheck("status_reset", STATUS, 32'h02);
`else
    readCheck("status_reset", STATUS, 32'h0);
`endif

    // byte lanes
    applyStimulus(1'b1, 1'b1, 32'h10, 4'b1111, 32'hAABBCCDD);
    #1 checkOutput("rd_during_write", ram_data_o, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h10, 4'b0101, 32'h11223344);
    readCheck("byte_lane", 32'h10, 32'hAA22CC44);

    // aliasing and decode holes
    applyStimulus(1'b1, 1'b1, 32'h1004, 4'b1111, 32'h12345678);
    readCheck("alias", 32'h4, 32'h12345678);
    readCheck("region2", 32'h2000_0000, 32'h0);
    readCheck("mmio_hole", 32'h1000_0008, 32'h0);
    readCheck("txdata_rd", TXDATA, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h4, 4'h0, 32'h0);
    #1 checkOutput("ce_low", ram_data_o, 32'h0);

    // random byte-lane writes against a model
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      applyStimulus(1'b1, 1'b1, 32'h100 + 32'(4 * i), 4'hF, d);
      model[i] = d;
    end
    for (int n = 0; n < 30; n++) begin
      idx = $urandom_range(0, 15);
      sel = 4'($urandom);
      d = $urandom;
      applyStimulus(1'b1, 1'b1, 32'h100 + 32'(4 * idx), sel, d);
      for (int l = 0; l < 4; l++) if (sel[l]) model[idx][8*l +: 8] = d[8*l +: 8];
    end
    for (int i = 0; i < 16; i++) readCheck("rand_ram", 32'h100 + 32'(4 * i), model[i]);

`ifdef DATA_BUS_UART_EN
    // one frame of 0x55: idle cycle, start, 8 data bits LSB first, stop, idle
    b = 8'h55;
    applyStimulus(1'b1, 1'b1, TXDATA, 4'b0001, {24'h0, b});
    txQ.push_back(1'b1);
    repeat (4) txQ.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (4) txQ.push_back(b[i]);
    repeat (4) txQ.push_back(1'b1);
    txQ.push_back(1'b1);
    for (int k = 0; k < 42; k++) begin
      applyStimulus(1'b1, 1'b0, STATUS, 4'h0, 32'h0);
      #1 checkOutput("tx_frame", {31'b0, uart_tx_o}, {31'b0, txQ.pop_front()});
      checkOutput("busy", {31'b0, ram_data_o[2]}, {31'b0, (k >= 1 && k <= 40)});
    end

    // fill the FIFO while the first byte is being sent; the tenth push is dropped
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, TXDATA, 4'b0001, 32'hA0 + 32'(i));
    readCheck("status_full", STATUS, 32'h8D);
    applyStimulus(1'b1, 1'b1, STATUS, 4'b0001, 32'h8);
    readCheck("ovf_clear", STATUS, 32'h85);

    // reset in the middle of that frame
    @(negedge clk);
    rst = 1'b1; ram_ce_i = 1'b1; ram_we_i = 1'b0; ram_addr_i = 32'h10;
    #1 checkOutput("rd_rst_mid", ram_data_o, 32'h0);
    @(negedge clk);
    #1 checkOutput("tx_after_rst", {31'b0, uart_tx_o}, 32'h1);
    rst = 1'b0;
    readCheck("status_after_rst", STATUS, 32'h02);
`else
    applyStimulus(1'b1, 1'b1, TXDATA, 4'b0001, 32'h55);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 1'b0, STATUS, 4'h0, 32'h0);
      #1 checkOutput("tx_idle", {31'b0, uart_tx_o}, 32'h1);
      checkOutput("status_zero", ram_data_o, 32'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
    readCheck("ram_kept_10", 32'h10, 32'hAA22CC44);
    readCheck("ram_kept_4", 32'h4, 32'h12345678);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      #1 checkOutput("tx_quiet", {31'b0, uart_tx_o}, 32'h1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/data_bus.md
# data_bus

Data-side memory subsystem directly downstream of the core's MEM stage. It consumes the core's `ram_*` request port and returns read data in the same cycle, as the MEM stage expects. Requests decode to an internal word-organised data RAM with byte-lane writes, or to a memory-mapped transmit-only UART. The UART has a TX FIFO and an 8N1 serializer that drains autonomously.

## Interface
- `RAM_WORDS`, 1024: data RAM depth in 32-bit words; must be a power of two.
- `FIFO_DEPTH`, 8: TX FIFO entries; must be a power of two, at most 8.
- `BAUD_DIV`, 434: clock cycles per UART bit; must be at least 2.

Ports (one clock; reset is synchronous and active-high, named as in the core):
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ram_ce_i` in 1: request valid.
- `ram_we_i` in 1: 1 = write, 0 = read.
- `ram_addr_i` in 32: byte address.
- `ram_sel_i` in 4: byte-lane enables; bit i covers data[8i+7:8i].
- `ram_data_i` in 32: write data from the core.
- `ram_data_o` out 32: read data to the core (combinational).
- `uart_tx_o` out 1: serial output, idle high.

## Operation
- Decode:
  - RAM: `ram_addr_i[31:28]==0`. Word index is `ram_addr_i[log2(RAM_WORDS)+1:2]`; higher address bits alias.
  - MMIO: `ram_addr_i[31:28]==1`. TXDATA is at 0x1000_0000, STATUS at 0x1000_0004. Other MMIO offsets read 0 and ignore writes.
  - All other regions read 0 and ignore writes.
- Read (`ce=1, we=0`):
  - `ram_data_o` = RAM word, STATUS, or 0, per decode.
  - `ram_sel_i` is ignored on reads; the full word is returned.
  - When `ce=0`, when writing, or while `rst=1`, `ram_data_o` = 0.
- RAM write:
  - Each lane with `sel[i]=1` is updated at the edge.
  - Lanes with `sel[i]=0` are unchanged.
- TXDATA write with `sel[0]=1`:
  - Pushes `ram_data_i[7:0]` into the FIFO.
  - If the FIFO is full and no pop occurs in the same cycle, the byte is dropped and sticky `overflow` is set.
  - A push on a full FIFO with a simultaneous pop is accepted, so the FIFO stays full.
  - Reads of TXDATA return 0.
- STATUS read fields:
  - [0] `full`
  - [1] `empty`
  - [2] `busy` (serializer not IDLE)
  - [3] `overflow`
  - [7:4] FIFO count
  - [31:8] 0
- STATUS write with `sel[0]=1` and `ram_data_i[3]=1` clears `overflow`. A set and a clear in the same cycle leave `overflow` set.
- Serializer FSM, states IDLE, START, DATA, STOP:
  - IDLE: `tx=1`. If the FIFO is non-empty: pop, load the shift register, set the baud counter to `BAUD_DIV-1`, go to START.
  - START: `tx=0` for `BAUD_DIV` cycles.
  - DATA: 8 bits LSB first, `BAUD_DIV` cycles each; the bit counter runs 0..7.
  - STOP: `tx=1` for `BAUD_DIV` cycles, then IDLE.
  - The baud counter decrements every cycle; the state or bit advances when it reaches 0.

## Timing
- Reset values:
  - `uart_tx_o=1`, FIFO empty (count 0), `overflow=0`, state IDLE, counters 0.
  - `ram_data_o=0` while `rst=1`.
  - RAM contents are not reset.
- Read latency is 0 cycles, combinational from the request inputs.
- A read of a RAM word written in the same cycle returns the pre-write value.
- Writes take effect at the request's rising edge.
- UART latency:
  - Push at edge N; the FIFO is non-empty after N.
  - IDLE pops at edge N+1, and `uart_tx_o` falls after edge N+1.
- Frame length is exactly `10*BAUD_DIV` cycles.
- Back-to-back bytes: STOP → IDLE, then pop on the next edge, giving one extra idle-high cycle between frames.
- FIFO pointers wrap modulo `FIFO_DEPTH`; count saturates at `FIFO_DEPTH`.
- Reset mid-frame aborts the frame: `uart_tx_o=1` after the reset edge, FIFO contents are discarded, and the RAM is untouched.

## Configuration
- `DATA_BUS_UART_EN` defined:
  - The UART, FIFO and STATUS are built as described.
- `DATA_BUS_UART_EN` undefined:
  - No FIFO or serializer logic.
  - All MMIO addresses read 0 and ignore writes.
  - `uart_tx_o` is tied to 1.
  - RAM behaviour is unchanged.

## Test plan
- Byte-lane write: write 0xAABBCCDD with sel 4'b1111 to 0x0000_0010, then 0x11223344 with sel 4'b0101 → read returns 0xAA22CC44.
- Aliasing: with `RAM_WORDS=1024`, write 0x12345678 to 0x0000_1004 → read of 0x0000_0004 returns 0x12345678; read of 0x2000_0000 returns 0.
- UART frame: `BAUD_DIV=4`, push 0x55 → `uart_tx_o` falls one cycle after the push edge. Then the low start bit for 4 cycles, bits 1,0,1,0,1,0,1,0 for 4 cycles each, and the stop bit high for 4 cycles. STATUS `busy=1` throughout the frame.
- FIFO full/overflow: `FIFO_DEPTH=8`, `BAUD_DIV=4`. Push 10 bytes in consecutive cycles starting from idle: the first is popped at the following edge, the FIFO fills after the 9th push, and the 10th is dropped → STATUS = count 8, `full=1`, `overflow=1`. Write 0x8 to STATUS → `overflow=0`.
- Reset mid-frame: assert `rst` at cycle 10 of a frame → `uart_tx_o=1`, STATUS=0x02, and previously written RAM data is still readable.
- With `DATA_BUS_UART_EN` undefined: write to TXDATA → `uart_tx_o` stays 1 and a STATUS read returns 0.
